// File: rtl/seg_to_bcd_capture.sv
// Multiplexed active-low 7-segment bus reader: synchronises, qualifies stability, decodes back to BCD.
// Optional macro HEX_DECODE_EN makes the A-F segment patterns decodable as well.
module seg_to_bcd_capture #(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_SAMPLES = 4,
  parameter int CNT_W          = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_en,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    bus_fault
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int LOW_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(STABLE_SAMPLES - 2);

  typedef enum logic {IDLE, TRACK} state_t;

  logic [NUM_DIGITS-1:0] an_s1, an_s2;
  logic [6:0]            seg_s1, seg_s2;

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [6:0]            seg_latched;
  logic [CNT_W-1:0]      count;
  logic                  committed;
  logic [NUM_DIGITS-1:0] seen;

  logic [LOW_W-1:0]      low_cnt;
  logic [IDX_W-1:0]      low_idx;
  logic [3:0]            dec_val;
  logic                  dec_ok;
  logic [NUM_DIGITS-1:0] seen_or;

  // Synchronisers idle at all-ones so reset looks like a dark display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1  <= '1;
      an_s2  <= '1;
      seg_s1 <= '1;
      seg_s2 <= '1;
    end else begin
      an_s1  <= an;
      an_s2  <= an_s1;
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
    end
  end

  always_comb begin
    low_cnt = '0;
    low_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s2[i]) begin
        low_cnt = low_cnt + LOW_W'(1);
        low_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'd0;
    case (seg_latched)
      7'b0000001: dec_val = 4'd0;
      7'b1001111: dec_val = 4'd1;
      7'b0010010: dec_val = 4'd2;
      7'b0000110: dec_val = 4'd3;
      7'b1001100: dec_val = 4'd4;
      7'b0100100: dec_val = 4'd5;
      7'b0100000: dec_val = 4'd6;
      7'b0001111: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0000100: dec_val = 4'd9;
`ifdef HEX_DECODE_EN
      7'b0001000: dec_val = 4'hA;
      7'b1100000: dec_val = 4'hB;
      7'b0110001: dec_val = 4'hC;
      7'b1000010: dec_val = 4'hD;
      7'b0110000: dec_val = 4'hE;
      7'b0111000: dec_val = 4'hF;
`endif
      default:    dec_ok  = 1'b0;
    endcase
  end

  assign seen_or = seen | (NUM_DIGITS'(1) << idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      seg_latched <= '1;
      count       <= '0;
      committed   <= 1'b0;
      seen        <= '0;
      digits      <= '0;
      digit_blank <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      bus_fault   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (sample_en) begin
        if (low_cnt == LOW_W'(1)) begin
          if (state == IDLE || low_idx != idx || seg_s2 != seg_latched) begin
            state       <= TRACK;
            idx         <= low_idx;
            seg_latched <= seg_s2;
            count       <= '0;
            committed   <= 1'b0;
          end else begin
            if (count != CNT_LAST) count <= count + CNT_W'(1);
            // This sample is the last of the required identical run.
            if (count == CNT_PRE && !committed) begin
              committed <= 1'b1;
              if (seg_latched == 7'b1111111) begin
                digit_blank[idx] <= 1'b1;
                digit_err[idx]   <= 1'b0;
              end else if (dec_ok) begin
                digits[4*idx +: 4] <= dec_val;
                digit_blank[idx]   <= 1'b0;
                digit_err[idx]     <= 1'b0;
              end else begin
                digit_blank[idx] <= 1'b0;
                digit_err[idx]   <= 1'b1;
              end
              if (&seen_or) begin
                seen        <= '0;
                frame_valid <= 1'b1;
              end else begin
                seen <= seen_or;
              end
            end
          end
        end else begin
          state <= IDLE;
          count <= '0;
          if (low_cnt > LOW_W'(1)) bus_fault <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_to_bcd_capture.sv
// Bench for seg_to_bcd_capture: directed scenarios plus random dwells checked against a run-length model.
module tb_seg_to_bcd_capture;
  localparam int N = 4;
  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_en = 1'b0;
  logic [N-1:0] an = '1;
  logic [6:0] seg = '1;
  logic [4*N-1:0] digits;
  logic [N-1:0] digit_blank, digit_err;
  logic frame_valid, bus_fault;

  int checks = 0;
  int failures = 0;
  int frames = 0;

  seg_to_bcd_capture #(.NUM_DIGITS(N), .STABLE_SAMPLES(STABLE), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .an(an), .seg(seg),
    .digits(digits), .digit_blank(digit_blank), .digit_err(digit_err),
    .frame_valid(frame_valid), .bus_fault(bus_fault)
  );

  always #5 clk = ~clk;

  logic [6:0] pats [0:15];
  initial begin
    pats[0] = 7'b0000001; pats[1] = 7'b1001111; pats[2] = 7'b0010010; pats[3] = 7'b0000110;
    pats[4] = 7'b1001100; pats[5] = 7'b0100100; pats[6] = 7'b0100000; pats[7] = 7'b0001111;
    pats[8] = 7'b0000000; pats[9] = 7'b0000100; pats[10] = 7'b0001000; pats[11] = 7'b1100000;
    pats[12] = 7'b0110001; pats[13] = 7'b1000010; pats[14] = 7'b0110000; pats[15] = 7'b0111000;
  end

  function automatic int decode(input logic [6:0] s);
    int lim;
`ifdef HEX_DECODE_EN
    lim = 16;
`else
    lim = 10;
`endif
    for (int k = 0; k < lim; k++) if (pats[k] == s) return k;
    return -1;
  endfunction

  // Model: pins reach the decision logic two edges late; a commit happens on the
  // STABLE-th consecutive identical one-hot qualified sample.
  logic [N-1:0] pin_an [0:1];
  logic [6:0]   pin_seg [0:1];
  logic [N-1:0] last_an;
  logic [6:0]   last_seg;
  int           run;
  int           m_dig [0:N-1];
  logic [N-1:0] m_blank, m_err, m_seen;
  logic         m_frame, m_fault;

  task automatic model_reset();
    pin_an[0] = '1; pin_an[1] = '1; pin_seg[0] = '1; pin_seg[1] = '1;
    last_an = '1; last_seg = '1; run = 0;
    for (int k = 0; k < N; k++) m_dig[k] = 0;
    m_blank = '0; m_err = '0; m_seen = '0; m_frame = 1'b0; m_fault = 1'b0;
  endtask

  task automatic model_step();
    logic [N-1:0] s_an;
    logic [6:0] s_seg;
    int lows, pos, v;
    s_an = pin_an[1]; s_seg = pin_seg[1];
    pin_an[1] = pin_an[0]; pin_seg[1] = pin_seg[0];
    pin_an[0] = an; pin_seg[0] = seg;
    m_frame = 1'b0;
    if (sample_en) begin
      lows = 0; pos = 0;
      for (int k = 0; k < N; k++) if (!s_an[k]) begin lows++; pos = k; end
      if (lows == 1) begin
        if (run > 0 && s_an == last_an && s_seg == last_seg) run++;
        else begin run = 1; last_an = s_an; last_seg = s_seg; end
        if (run == STABLE) begin
          v = decode(s_seg);
          if (s_seg == 7'b1111111) begin m_blank[pos] = 1'b1; m_err[pos] = 1'b0; end
          else if (v < 0) begin m_blank[pos] = 1'b0; m_err[pos] = 1'b1; end
          else begin m_dig[pos] = v; m_blank[pos] = 1'b0; m_err[pos] = 1'b0; end
          m_seen[pos] = 1'b1;
          if (&m_seen) begin m_frame = 1'b1; m_seen = '0; end
        end
      end else begin
        run = 0;
        if (lows > 1) m_fault = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, DUT against model.
  initial begin
    logic [4*N-1:0] exp_dig;
    forever begin
      @(negedge clk);
      exp_dig = '0;
      for (int k = 0; k < N; k++) exp_dig[4*k +: 4] = 4'(m_dig[k]);
      chk("digits", 32'(digits), 32'(exp_dig));
      chk("digit_blank", 32'(digit_blank), 32'(m_blank));
      chk("digit_err", 32'(digit_err), 32'(m_err));
      chk("frame_valid", 32'(frame_valid), 32'(m_frame));
      chk("bus_fault", 32'(bus_fault), 32'(m_fault));
      if (frame_valid === 1'b1) frames++;
    end
  end

  task automatic cycle(input logic [N-1:0] a, input logic [6:0] s, input logic e);
    @(negedge clk);
    #1;
    an = a; seg = s; sample_en = e;
  endtask

  task automatic dwell(input logic [N-1:0] a, input logic [6:0] s, input int ticks);
    cycle(a, s, 1'b0);
    cycle(a, s, 1'b0);
    for (int t = 0; t < ticks; t++) begin
      cycle(a, s, 1'b1);
      cycle(a, s, 1'b0);
    end
  endtask

  initial begin
    int f0;
    logic [N-1:0] ra;
    logic [6:0] rs;
    int nc;
    rst_n = 1'b0;
    repeat (3) cycle('1, '1, 1'b0);
    chk("reset_outputs", {digits, digit_blank, digit_err, frame_valid, bus_fault}, 32'd0);
    cycle('1, '1, 1'b0);
    rst_n = 1'b1;

    // 1: digit0 shows 5
    dwell(4'b1110, pats[5], 4);
    chk("t1_digit0", 32'(digits[3:0]), 32'd5);
    chk("t1_err0", 32'(digit_err[0]), 32'd0);
    $display("phase1 digits=%h err=%b", digits, digit_err);

    // 2: full frame 1..4, long dwells
    f0 = frames;
    dwell(4'b1110, pats[1], 6);
    dwell(4'b1101, pats[2], 6);
    dwell(4'b1011, pats[3], 6);
    dwell(4'b0111, pats[4], 6);
    chk("t2_digits", 32'(digits), 32'h4321);
    chk("t2_frames", 32'(frames - f0), 32'd1);
    $display("phase2 digits=%h frames=%0d", digits, frames - f0);

    // 3: unstable digit1 never commits
    for (int r = 0; r < 4; r++) dwell(4'b1101, pats[6 + (r % 2)], 3);
    chk("t3_digit1", 32'(digits[7:4]), 32'd2);
    $display("phase3 digits=%h", digits);

    // 4: two anodes low
    dwell(4'b1100, pats[8], 1);
    chk("t4_fault", 32'(bus_fault), 32'd1);
    dwell(4'b1110, pats[9], 4);
    chk("t4_digit0", 32'(digits[3:0]), 32'd9);
    $display("phase4 fault=%b digits=%h", bus_fault, digits);

    // 5: blank then hex A on digit2
    dwell(4'b1011, 7'b1111111, 4);
    chk("t5_blank2", 32'(digit_blank[2]), 32'd1);
    dwell(4'b1011, pats[10], 4);
`ifdef HEX_DECODE_EN
    chk("t5_hex_digit2", 32'(digits[11:8]), 32'hA);
    chk("t5_hex_err2", 32'(digit_err[2]), 32'd0);
`else
    chk("t5_hex_digit2", 32'(digits[11:8]), 32'd3);
    chk("t5_hex_err2", 32'(digit_err[2]), 32'd1);
`endif
    chk("t5_blank2_clr", 32'(digit_blank[2]), 32'd0);
    $display("phase5 digits=%h blank=%b err=%b", digits, digit_blank, digit_err);

    // 6: reset at tick 2 of a dwell
    cycle(4'b0111, pats[7], 1'b0);
    cycle(4'b0111, pats[7], 1'b0);
    cycle(4'b0111, pats[7], 1'b1);
    cycle(4'b0111, pats[7], 1'b0);
    cycle(4'b0111, pats[7], 1'b1);
    @(negedge clk); #1 rst_n = 1'b0;
    cycle(4'b0111, pats[7], 1'b0);
    cycle(4'b0111, pats[7], 1'b0);
    chk("t6_reset_outputs", {digits, digit_blank, digit_err, frame_valid, bus_fault}, 32'd0);
    f0 = frames;
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (12) cycle(4'b0111, pats[7], 1'b1);
    chk("t6_no_frame", 32'(frames - f0), 32'd0);
    $display("phase6 digits=%h frames=%0d", digits, frames - f0);

    // Random dwells
    for (int d = 0; d < 400; d++) begin
      if ($urandom_range(99) < 85) ra = ~(4'b0001 << $urandom_range(N - 1));
      else ra = 4'($urandom);
      if ($urandom_range(9) == 0) rs = 7'($urandom);
      else if ($urandom_range(16) == 16) rs = 7'b1111111;
      else rs = pats[$urandom_range(15)];
      nc = $urandom_range(12, 1);
      for (int c = 0; c < nc; c++) cycle(ra, rs, ($urandom_range(3) != 0));
      if ($urandom_range(149) == 0) begin
        @(negedge clk); #1 rst_n = 1'b0;
        cycle(ra, rs, 1'b1);
        @(negedge clk); #1 rst_n = 1'b1;
      end
    end
    repeat (4) cycle('1, '1, 1'b0);
    $display("random phase done frames=%0d", frames);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
